// File: rtl/gpr_pkg.sv
// Shared constants and packed-slice helper for the GPR writeback arbiter.
package gpr_pkg;

  localparam int unsigned GPR_ISA_WIDTH = 32;
  localparam int unsigned GPR_REG_NUM_W = 5;
  localparam int unsigned GPR_REQ_NUM   = 2;
  localparam int unsigned GPR_NUM       = 2 ** GPR_REG_NUM_W;
  localparam int unsigned GPR_ZERO      = 0;

  // LSB position of requester idx inside a packed per-requester bus of width w.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; owns the pointer.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next_c;

  // Scan from the pointer with wrap; the first hit is kept.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      idx = sum[IDX_W-1:0];
      if (en && req[idx] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end

  assign ptr_next_c = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= ptr_next_c;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port among REQ_NUM writeback requesters through a one-entry stage.
// Optional pending-write scoreboard enabled by defining GPR_WB_SCOREBOARD_EN.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned ISA_WIDTH          = GPR_ISA_WIDTH,
  parameter int unsigned REGISTER_NUM_WIDTH = GPR_REG_NUM_W,
  parameter int unsigned REQ_NUM            = GPR_REQ_NUM
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQ_NUM-1:0]                     req_valid,
  output logic [REQ_NUM-1:0]                     req_ready,
  input  logic [REQ_NUM*REGISTER_NUM_WIDTH-1:0]  req_waddr,
  input  logic [REQ_NUM*ISA_WIDTH-1:0]           req_wdata,
  input  logic                                   gpr_stall,
  output logic                                   gpr_wen,
  output logic [REGISTER_NUM_WIDTH-1:0]          gpr_waddr,
  output logic [ISA_WIDTH-1:0]                   gpr_wdata,
  input  logic                                   claim_valid,
  input  logic [REGISTER_NUM_WIDTH-1:0]          claim_addr,
  output logic [2**REGISTER_NUM_WIDTH-1:0]       busy_vec
);

  localparam int unsigned IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned REG_W = REGISTER_NUM_WIDTH;

  logic                          free_c;
  logic                          grant_valid_c;
  logic [IDX_W-1:0]              grant_idx_c;
  logic [REG_W-1:0]              sel_waddr_c;
  logic [ISA_WIDTH-1:0]          sel_wdata_c;

  // gpr_wen doubles as the stage-valid flag.
  assign free_c = !gpr_wen || !gpr_stall;

  rr_arbiter #(.N(REQ_NUM), .IDX_W(IDX_W)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .en          (free_c && rst),
    .grant       (req_ready),
    .grant_idx   (grant_idx_c),
    .grant_valid (grant_valid_c)
  );

  assign sel_waddr_c = req_waddr[slice_lsb(32'(grant_idx_c), REG_W) +: REG_W];
  assign sel_wdata_c = req_wdata[slice_lsb(32'(grant_idx_c), ISA_WIDTH) +: ISA_WIDTH];

  // Writes to x0 are acknowledged but never enter the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else if (free_c) begin
      if (grant_valid_c && (sel_waddr_c != REG_W'(GPR_ZERO))) begin
        gpr_wen   <= 1'b1;
        gpr_waddr <= sel_waddr_c;
        gpr_wdata <= sel_wdata_c;
      end else begin
        gpr_wen   <= 1'b0;
      end
    end
  end

`ifdef GPR_WB_SCOREBOARD_EN
  logic                    commit_c;
  logic [2**REG_W-1:0]     busy_q;

  assign commit_c = gpr_wen && !gpr_stall;

  // Set is applied after clear so a same-cycle claim of the committing index stays busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      if (commit_c) busy_q[gpr_waddr] <= 1'b0;
      if (claim_valid && (claim_addr != REG_W'(GPR_ZERO))) busy_q[claim_addr] <= 1'b1;
    end
  end

  assign busy_vec = busy_q;
`else
  logic unused_claim;
  assign unused_claim = ^{claim_valid, claim_addr};
  assign busy_vec     = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter (REQ_NUM=2, 32-bit data, 5-bit index).
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_waddr;
  logic [63:0] req_wdata;
  logic        gpr_stall;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

`ifdef GPR_WB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  gpr_wb_arbiter #(.ISA_WIDTH(32), .REGISTER_NUM_WIDTH(5), .REQ_NUM(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_waddr   (req_waddr),
    .req_wdata   (req_wdata),
    .gpr_stall   (gpr_stall),
    .gpr_wen     (gpr_wen),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_waddr[i*5 +: 5]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic chk_stage(input string tag, input logic wen, input logic [4:0] a,
                           input logic [31:0] d);
    chk({tag, "_wen"}, 64'(gpr_wen), 64'(wen));
    chk({tag, "_waddr"}, 64'(gpr_waddr), 64'(a));
    chk({tag, "_wdata"}, 64'(gpr_wdata), 64'(d));
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_waddr = '0; req_wdata = '0;
    gpr_stall = 1'b0; claim_valid = 1'b0; claim_addr = '0;

    // Reset held with both requesters valid
    set_req(0, 1'b1, 5'd5, 32'h11);
    set_req(1, 1'b1, 5'd6, 32'h22);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk_stage("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_busy", 64'(busy_vec), 64'h0);
    tick(); tick();
    chk("rst_ready_clk", 64'(req_ready), 64'h0);
    chk("rst_wen_clk", 64'(gpr_wen), 64'h0);
    rst = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);

    // Round-robin with both valid
    tick(); chk_stage("rr1", 1'b1, 5'd5, 32'h11); chk("rr1_ready", 64'(req_ready), 64'h2);
    tick(); chk_stage("rr2", 1'b1, 5'd6, 32'h22); chk("rr2_ready", 64'(req_ready), 64'h1);
    tick(); chk_stage("rr3", 1'b1, 5'd5, 32'h11); chk("rr3_ready", 64'(req_ready), 64'h2);
    tick(); chk_stage("rr4", 1'b1, 5'd6, 32'h22);
    req_valid = 2'b00;
    tick(); chk("rr_drain_wen", 64'(gpr_wen), 64'h0);

    // Stall with stage holding x7
    set_req(0, 1'b1, 5'd7, 32'hDEAD);
    #1; chk("st_ready0", 64'(req_ready), 64'h1);
    tick(); chk_stage("st_load", 1'b1, 5'd7, 32'hDEAD);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd8, 32'hBEEF);
    gpr_stall = 1'b1;
    #1; chk("st_ready_blk", 64'(req_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_stage("st_hold", 1'b1, 5'd7, 32'hDEAD);
      chk("st_hold_ready", 64'(req_ready), 64'h0);
    end
    gpr_stall = 1'b0;
    #1; chk("st_release_ready", 64'(req_ready), 64'h2);
    tick(); chk_stage("st_nobubble", 1'b1, 5'd8, 32'hBEEF);
    req_valid = 2'b00;
    tick(); chk("st_drain_wen", 64'(gpr_wen), 64'h0);

    // Stall with empty stage: grant proceeds, then holds
    gpr_stall = 1'b1;
    set_req(0, 1'b1, 5'd9, 32'h99);
    #1; chk("se_ready", 64'(req_ready), 64'h1);
    tick(); chk_stage("se_load", 1'b1, 5'd9, 32'h99);
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1; chk("se_ready_blk", 64'(req_ready), 64'h0);
    tick(); chk_stage("se_hold", 1'b1, 5'd9, 32'h99);
    gpr_stall = 1'b0;
    tick(); chk("se_commit_wen", 64'(gpr_wen), 64'h0);

    // Write to x0 is acked but absorbed; pointer advances to 0
    set_req(1, 1'b1, 5'd0, 32'hFFFF);
    #1; chk("x0_ready", 64'(req_ready), 64'h2);
    tick(); chk("x0_wen", 64'(gpr_wen), 64'h0);
    set_req(0, 1'b1, 5'd5, 32'h11);
    set_req(1, 1'b1, 5'd6, 32'h22);
    #1; chk("x0_ptr", 64'(req_ready), 64'h1);
    tick(); chk_stage("x0_next", 1'b1, 5'd5, 32'h11);

    // Async reset with stage valid, mid-cycle
    rst = 1'b0;
    #2;
    chk_stage("areset", 1'b0, 5'd0, 32'h0);
    chk("areset_ready", 64'(req_ready), 64'h0);
    rst = 1'b1;
    #1; chk("areset_ptr", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    tick();

    // Scoreboard
    claim_valid = 1'b1; claim_addr = 5'd3;
    tick(); chk("sb_claim", 64'(busy_vec), SB_ON ? 64'h8 : 64'h0);
    claim_valid = 1'b0;
    set_req(0, 1'b1, 5'd3, 32'h33);
    tick(); chk_stage("sb_load", 1'b1, 5'd3, 32'h33);
    set_req(0, 1'b0, 5'd0, 32'h0);
    claim_valid = 1'b1; claim_addr = 5'd3;
    tick();
    chk("sb_setwins", 64'(busy_vec), SB_ON ? 64'h8 : 64'h0);
    chk("sb_commit_wen", 64'(gpr_wen), 64'h0);
    claim_addr = 5'd0;
    set_req(1, 1'b1, 5'd3, 32'h44);
    #1; chk("sb_ready", 64'(req_ready), 64'h2);
    tick();
    claim_valid = 1'b0;
    set_req(1, 1'b0, 5'd0, 32'h0);
    chk("sb_x0claim", 64'(busy_vec), SB_ON ? 64'h8 : 64'h0);
    chk_stage("sb_load2", 1'b1, 5'd3, 32'h44);
    tick(); chk("sb_clear", 64'(busy_vec), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
